// File: rtl/rx2inbox.sv
// Elastic byte FIFO between the UART receiver and the CPU INBOX.
// Drains one byte per two cycles while the INBOX is not full; counts bytes dropped when the FIFO is full.
module rx2inbox #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_wr,
  input  logic [7:0]            i_data,
  input  logic                  i_full,
  input  logic                  i_clr_ovf,
  output logic                  o_wr,
  output logic [7:0]            o_data,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_overflow,
  output logic [7:0]            o_drop_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_reg;
  logic [DEPTH_LOG2-1:0] rptr_reg;
  logic [DEPTH_LOG2:0]   level_reg;
  logic                  wr_reg;
  logic [7:0]            data_reg;
  logic                  overflow_reg;
  logic [7:0]            drop_count_reg;

  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;

  assign full  = (level_reg == LEVEL_FULL);
  assign empty = (level_reg == '0);
  // A pulse on o_wr blocks the next pop so the INBOX has a cycle to raise i_full.
  assign pop   = !empty && !i_full && !wr_reg;
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push  = i_wr && (!full || pop);
  assign drop  = i_wr && full && !pop;

  // Storage has no reset; only the pointers decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_reg] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      level_reg <= '0;
      wr_reg    <= 1'b0;
      data_reg  <= 8'h00;
    end else begin
      wr_reg <= pop;
      if (push) begin
        wptr_reg <= wptr_reg + 1'b1;
      end
      if (pop) begin
        rptr_reg <= rptr_reg + 1'b1;
        data_reg <= mem[rptr_reg];
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // A drop on the same edge as a clear wins: the count restarts at one.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= 8'h00;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (i_clr_ovf) begin
        drop_count_reg <= 8'h01;
      end else if (drop_count_reg != 8'hFF) begin
        drop_count_reg <= drop_count_reg + 8'h01;
      end
    end else if (i_clr_ovf) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= 8'h00;
    end
  end

  assign o_wr         = wr_reg;
  assign o_data       = data_reg;
  assign o_level      = level_reg;
  assign o_overflow   = overflow_reg;
  assign o_drop_count = drop_count_reg;

endmodule

// File: tb/tb_rx2inbox.sv
// Directed self-checking bench for rx2inbox with a 4-entry FIFO.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rx2inbox;

  localparam int DL2 = 2;

  logic           clk;
  logic           i_rst;
  logic           i_wr;
  logic [7:0]     i_data;
  logic           i_full;
  logic           i_clr_ovf;
  logic           o_wr;
  logic [7:0]     o_data;
  logic [DL2:0]   o_level;
  logic           o_overflow;
  logic [7:0]     o_drop_count;

  int n_asserts = 0;
  int n_fail    = 0;

  rx2inbox #(.DEPTH_LOG2(DL2)) dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_wr         (i_wr),
    .i_data       (i_data),
    .i_full       (i_full),
    .i_clr_ovf    (i_clr_ovf),
    .o_wr         (o_wr),
    .o_data       (o_data),
    .o_level      (o_level),
    .o_overflow   (o_overflow),
    .o_drop_count (o_drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " o_wr"}, 32'(o_wr), 0);
    chk({tag, " o_data"}, 32'(o_data), 0);
    chk({tag, " o_level"}, 32'(o_level), 0);
    chk({tag, " o_overflow"}, 32'(o_overflow), 0);
    chk({tag, " o_drop_count"}, 32'(o_drop_count), 0);
  endtask

  // One idle cycle with no pulse, then a pulse carrying exp (2-cycle spacing).
  task automatic next_pulse(input string tag, input logic [7:0] exp, input int lvl);
    step();
    chk({tag, " gap o_wr"}, 32'(o_wr), 0);
    step();
    chk({tag, " o_wr"}, 32'(o_wr), 1);
    chk({tag, " o_data"}, 32'(o_data), 32'(exp));
    chk({tag, " o_level"}, 32'(o_level), 32'(lvl));
  endtask

  task automatic push_byte(input logic [7:0] b);
    i_wr   = 1'b1;
    i_data = b;
    step();
    i_wr   = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_wr = 1'b0; i_data = 8'h00; i_full = 1'b0; i_clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset_held");
    i_rst = 1'b0;
    step();
    chk_all_zero("after_release");

    // Single byte: pulse one cycle after the push edge.
    push_byte(8'h41);
    chk("single level1", 32'(o_level), 1);
    chk("single no_wr_yet", 32'(o_wr), 0);
    step();
    chk("single o_wr", 32'(o_wr), 1);
    chk("single o_data", 32'(o_data), 32'h41);
    chk("single level0", 32'(o_level), 0);
    step();
    chk("single pulse_end", 32'(o_wr), 0);
    chk("single data_held", 32'(o_data), 32'h41);

    // Back-pressure fill, then two drops.
    i_full = 1'b1;
    for (int k = 0; k < 4; k++) push_byte(8'h10 + 8'(k));
    chk("bp level4", 32'(o_level), 4);
    chk("bp no_wr", 32'(o_wr), 0);
    chk("bp no_ovf", 32'(o_overflow), 0);
    push_byte(8'h14);
    push_byte(8'h15);
    chk("ovf flag", 32'(o_overflow), 1);
    chk("ovf count2", 32'(o_drop_count), 2);
    chk("ovf level4", 32'(o_level), 4);

    // Release: four pulses 2 cycles apart, in order, without the dropped bytes.
    i_full = 1'b0;
    step();
    chk("drain0 o_wr", 32'(o_wr), 1);
    chk("drain0 o_data", 32'(o_data), 32'h10);
    chk("drain0 level", 32'(o_level), 3);
    next_pulse("drain1", 8'h11, 2);
    next_pulse("drain2", 8'h12, 1);
    next_pulse("drain3", 8'h13, 0);
    step();
    chk("drain end o_wr", 32'(o_wr), 0);
    step();
    chk("drain idle o_wr", 32'(o_wr), 0);
    chk("drain idle level", 32'(o_level), 0);

    // Full FIFO: push lands on the same edge as the first pop.
    i_full = 1'b1;
    for (int k = 0; k < 4; k++) push_byte(8'h30 + 8'(k));
    chk("sim full level", 32'(o_level), 4);
    i_full = 1'b0;
    push_byte(8'h20);
    chk("sim o_wr", 32'(o_wr), 1);
    chk("sim o_data", 32'(o_data), 32'h30);
    chk("sim level4", 32'(o_level), 4);
    chk("sim no_drop", 32'(o_drop_count), 2);
    next_pulse("sim1", 8'h31, 3);
    next_pulse("sim2", 8'h32, 2);
    next_pulse("sim3", 8'h33, 1);
    next_pulse("sim4", 8'h20, 0);
    step();
    chk("sim end o_wr", 32'(o_wr), 0);

    // Clear alone, then clear colliding with a drop.
    i_clr_ovf = 1'b1;
    step();
    i_clr_ovf = 1'b0;
    chk("clr ovf", 32'(o_overflow), 0);
    chk("clr count", 32'(o_drop_count), 0);
    i_full = 1'b1;
    for (int k = 0; k < 4; k++) push_byte(8'h50 + 8'(k));
    for (int k = 0; k < 5; k++) push_byte(8'hEE);
    chk("pre_collide count5", 32'(o_drop_count), 5);
    i_clr_ovf = 1'b1;
    push_byte(8'hEE);
    i_clr_ovf = 1'b0;
    chk("collide ovf", 32'(o_overflow), 1);
    chk("collide count1", 32'(o_drop_count), 1);

    // 300 more drops: count saturates at 255.
    i_wr = 1'b1;
    i_data = 8'hEE;
    for (int k = 0; k < 254; k++) step();
    chk("sat count255", 32'(o_drop_count), 255);
    for (int k = 0; k < 46; k++) step();
    i_wr = 1'b0;
    chk("sat hold255", 32'(o_drop_count), 255);
    chk("sat level4", 32'(o_level), 4);

    // Mid-burst async reset: one pulse out, three bytes still buffered.
    i_full = 1'b0;
    step();
    chk("midburst o_wr", 32'(o_wr), 1);
    chk("midburst o_data", 32'(o_data), 32'h50);
    chk("midburst level3", 32'(o_level), 3);
    #2 i_rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    #2 i_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst o_wr", 32'(o_wr), 0);
      chk("post_rst level", 32'(o_level), 0);
    end
    push_byte(8'h55);
    chk("post_rst push level", 32'(o_level), 1);
    step();
    chk("post_rst o_wr", 32'(o_wr), 1);
    chk("post_rst o_data", 32'(o_data), 32'h55);
    step();
    chk("post_rst final level", 32'(o_level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
